// File: rtl/nano_mem_arbiter_if.sv
// One master's access channel into the shared NanoCPU memory arbiter.
// The master holds req/we/addr/wdata stable until it sees ack; rdata is
// only meaningful in the cycle where ack is high.
interface nano_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/nano_mem_arbiter.sv
// Two-port arbiter sharing the 256 x 16 NanoCPU memory between the CPU
// (port0) and a second master (port1). A registered owner FSM hands the
// memory to one port at a time. Ties are broken round-robin. A burst
// counter bounds how long one port may keep the memory while the other
// waits. Handover between owners happens with no idle bubble.
module nano_mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int BURST_MAX = 4
) (
  input  logic                ck,
  input  logic                rst,
  nano_mem_arbiter_if.slave   port0,
  nano_mem_arbiter_if.slave   port1,
  output logic [1:0]          owner,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  // Last burst index a port may use while the other port is waiting.
  localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic last, last_nxt;

  logic req0, req1;
  logic we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic ce_c, we_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;

  assign req0   = port0.req;
  assign req1   = port1.req;
  assign we0    = port0.we;
  assign we1    = port1.we;
  assign addr0  = port0.addr;
  assign addr1  = port1.addr;
  assign wdata0 = port0.wdata;
  assign wdata1 = port1.wdata;

  // Owner state, burst count and last-served port; reset favours port0 on the first tie.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Ownership decisions: IDLE picks a port, an owner keeps the memory until it releases or its burst runs out.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (req0 && req1) begin
          state_nxt = last ? OWN0 : OWN1;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN0: begin
        if (!req0) begin
          state_nxt = req1 ? OWN1 : IDLE;
          last_nxt  = 1'b0;
          cnt_nxt   = 4'd0;
        end else if (req1 && (cnt == CNT_LAST)) begin
          state_nxt = OWN1;
          last_nxt  = 1'b0;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = (cnt == CNT_LAST) ? cnt : cnt + 4'd1;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_nxt = req0 ? OWN0 : IDLE;
          last_nxt  = 1'b1;
          cnt_nxt   = 4'd0;
        end else if (req0 && (cnt == CNT_LAST)) begin
          state_nxt = OWN0;
          last_nxt  = 1'b1;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = (cnt == CNT_LAST) ? cnt : cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Memory side and per-port responses follow the current owner; nothing reaches the memory in IDLE.
  always_comb begin
    ack0    = (state == OWN0) && req0;
    ack1    = (state == OWN1) && req1;
    ce_c    = ack0 || ack1;
    we_c    = (ack0 && we0) || (ack1 && we1);
    addr_c  = '0;
    wdata_c = '0;
    unique case (state)
      OWN0: begin
        addr_c  = addr0;
        wdata_c = wdata0;
      end
      OWN1: begin
        addr_c  = addr1;
        wdata_c = wdata1;
      end
      default: begin
        addr_c  = '0;
        wdata_c = '0;
      end
    endcase
    rdata0 = ack0 ? mem_rdata : '0;
    rdata1 = ack1 ? mem_rdata : '0;
  end

  assign port0.ack   = ack0;
  assign port1.ack   = ack1;
  assign port0.rdata = rdata0;
  assign port1.rdata = rdata1;

  assign owner     = state;
  assign mem_ce    = ce_c;
  assign mem_we    = we_c;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Testbench for nano_mem_arbiter: directed accesses with hand-computed
// expectations pushed into per-port queues, and a monitor that pops and
// compares whenever a port is acknowledged.
module tb_nano_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int BM = 4;

  logic ck  = 1'b0;
  logic rst = 1'b0;

  always #5 ck = ~ck;

  nano_mem_arbiter_if #(.AW(AW), .DW(DW)) p0_if ();
  nano_mem_arbiter_if #(.AW(AW), .DW(DW)) p1_if ();

  logic [1:0]    owner;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [256];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  nano_mem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
    .ck       (ck),
    .rst      (rst),
    .port0    (p0_if),
    .port1    (p1_if),
    .owner    (owner),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory array: combinational read, write on the rising edge; preload port for setup.
  assign mem_rdata = mem[mem_addr];
  always @(posedge ck) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_ce && mem_we) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic score_port(input int p);
    exp_t e;
    logic [DW-1:0] rd, other_rd;
    rd       = (p == 0) ? p0_if.rdata : p1_if.rdata;
    other_rd = (p == 0) ? p1_if.rdata : p0_if.rdata;
    if (((p == 0) ? q0.size() : q1.size()) == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_ack port%0d: got ack expected none at %0t", p, $time);
    end else begin
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("mem_ce p%0d", p), 32'(mem_ce), 32'd1);
      check($sformatf("mem_we p%0d", p), 32'(mem_we), 32'(e.we));
      check($sformatf("mem_addr p%0d", p), 32'(mem_addr), 32'(e.addr));
      if (e.we) check($sformatf("mem_wdata p%0d", p), 32'(mem_wdata), 32'(e.data));
      else      check($sformatf("rdata p%0d", p), 32'(rd), 32'(e.data));
      check($sformatf("idle_rdata p%0d", 1 - p), 32'(other_rd), 32'd0);
    end
  endtask

  // Monitor: every acknowledged access is matched against the next expectation for that port.
  always @(negedge ck) begin
    if (rst) begin
      if (p0_if.ack && p1_if.ack) check("dual_ack", 32'd1, 32'd0);
      if (p0_if.ack) score_port(0);
      if (p1_if.ack) score_port(1);
    end
  end

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      p0_if.req = r; p0_if.we = w; p0_if.addr = a; p0_if.wdata = d;
    end else begin
      p1_if.req = r; p1_if.we = w; p1_if.addr = a; p1_if.wdata = d;
    end
  endtask

  // Issues one access, records its expectation, and returns at the edge that completes it.
  task automatic applyStimulus(input int p, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                               output int cycles);
    exp_t e;
    logic got;
    e.we = w; e.addr = a; e.data = w ? d : exp_rd;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    set_port(p, 1'b1, w, a, d);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 20) begin
      @(negedge ck);
      cycles++;
      got = (p == 0) ? p0_if.ack : p1_if.ack;
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL ack_timeout port%0d: got no ack expected ack within 20 cycles", p);
    end
    @(posedge ck);
    #1;
  endtask

  task automatic drop_req(input int p);
    set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge ck);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge ck);
    #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, n1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;

    // Reset held with random requests: nothing may be granted.
    for (int i = 0; i < 4; i++) begin
      @(posedge ck);
      #1;
      set_port(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
      set_port(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
      @(negedge ck);
      check("rst ack0", 32'(p0_if.ack), 32'd0);
      check("rst ack1", 32'(p1_if.ack), 32'd0);
      check("rst mem_ce", 32'(mem_ce), 32'd0);
      check("rst mem_we", 32'(mem_we), 32'd0);
      check("rst owner", 32'(owner), 32'd0);
    end
    drop_req(0);
    drop_req(1);
    idle_cycle();
    rst = 1'b1;
    @(negedge ck);
    check("post_rst owner", 32'(owner), 32'd0);

    preload(8'h14, 16'h000E);
    preload(8'h30, 16'h5555);
    idle_cycle();

    // Single read from IDLE: ack one cycle after req.
    applyStimulus(0, 1'b0, 8'h14, 16'h0000, 16'h000E, n);
    check("read latency", 32'(n), 32'd2);
    drop_req(0);
    idle_cycle();

    // Port1 write then port0 read-back.
    applyStimulus(1, 1'b1, 8'h15, 16'hBEEF, 16'h0000, n);
    check("write latency", 32'(n), 32'd2);
    drop_req(1);
    idle_cycle();
    applyStimulus(0, 1'b0, 8'h15, 16'h0000, 16'hBEEF, n);
    drop_req(0);
    idle_cycle();

    // Contention from reset release: IDLE, OWN0 x4, OWN1 x4, OWN0 x4, OWN1 x4.
    rst = 1'b0;
    idle_cycle();
    rst = 1'b1;
    fork
      begin
        int c;
        for (int i = 0; i < 8; i++)
          applyStimulus(0, 1'b1, 8'(8'h40 + i), 16'(16'hA000 + i), 16'h0000, c);
        drop_req(0);
      end
      begin
        int c;
        for (int i = 0; i < 8; i++)
          applyStimulus(1, 1'b1, 8'(8'h80 + i), 16'(16'hB000 + i), 16'h0000, c);
        drop_req(1);
      end
      begin
        logic [1:0] exp_own;
        for (int k = 0; k < 17; k++) begin
          @(negedge ck);
          if (k == 0) exp_own = 2'b00;
          else exp_own = ((((k - 1) / BM) % 2) == 0) ? 2'b01 : 2'b10;
          check($sformatf("contention owner[%0d]", k), 32'(owner), 32'(exp_own));
          if (k > 0) check($sformatf("contention mem_ce[%0d]", k), 32'(mem_ce), 32'd1);
        end
      end
    join
    idle_cycle();
    idle_cycle();
    applyStimulus(0, 1'b0, 8'h43, 16'h0000, 16'hA003, n);
    drop_req(0);
    idle_cycle();
    applyStimulus(1, 1'b0, 8'h87, 16'h0000, 16'hB007, n);
    drop_req(1);
    idle_cycle();

    // Early release: port0 drops req in its cnt=1 cycle, port1 gets the memory next cycle.
    fork
      begin
        int c;
        applyStimulus(0, 1'b0, 8'h40, 16'h0000, 16'hA000, c);
        drop_req(0);
        @(negedge ck);
        check("early owner", 32'(owner), 32'd1);
        check("early ack1_off", 32'(p1_if.ack), 32'd0);
        @(negedge ck);
        check("handover owner", 32'(owner), 32'd2);
        check("handover ack1", 32'(p1_if.ack), 32'd1);
      end
      begin
        int c;
        idle_cycle();
        applyStimulus(1, 1'b0, 8'h80, 16'h0000, 16'hB000, c);
        check("handover wait", 32'(c), 32'd3);
        drop_req(1);
      end
    join
    idle_cycle();
    idle_cycle();

    // Reset mid OWN1 write: access dropped asynchronously, memory untouched.
    set_port(1, 1'b1, 1'b1, 8'h30, 16'h1234);
    @(posedge ck);
    #2;
    check("pre_rst owner", 32'(owner), 32'd2);
    rst = 1'b0;
    #1;
    check("async ack1", 32'(p1_if.ack), 32'd0);
    check("async mem_we", 32'(mem_we), 32'd0);
    check("async mem_ce", 32'(mem_ce), 32'd0);
    check("async owner", 32'(owner), 32'd0);
    @(posedge ck);
    #1;
    check("mem unchanged", 32'(mem[8'h30]), 32'h5555);
    rst = 1'b1;
    fork
      begin
        int c;
        applyStimulus(0, 1'b0, 8'h30, 16'h0000, 16'h5555, c);
        drop_req(0);
      end
      begin
        applyStimulus(1, 1'b0, 8'h15, 16'h0000, 16'hBEEF, n1);
        drop_req(1);
      end
      begin
        @(negedge ck);
        check("rst_tie owner0", 32'(owner), 32'd0);
        @(negedge ck);
        check("rst_tie owner1", 32'(owner), 32'd1);
      end
    join
    idle_cycle();
    idle_cycle();

    checkOutput();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic checkOutput();
    check("q0 drained", 32'(q0.size()), 32'd0);
    check("q1 drained", 32'(q1.size()), 32'd0);
  endtask

endmodule

// File: doc/nano_mem_arbiter.md
# nano_mem_arbiter

Two-port arbiter that shares the single 256 x 16 NanoCPU memory between the CPU (port 0) and a second master (port 1), such as a program loader, DMA engine or debug port. It sequences ownership of the memory with a registered owner FSM, round-robin tie-breaking and a bounded burst length, so neither master can starve the other. It sits between the masters and the memory array. The memory is read combinationally and written on the rising edge.

## Interface
Parameters:
- AW, 8, address width (256 words)
- DW, 16, data width
- BURST_MAX, 4, maximum consecutive accesses granted to one port while the other port is requesting; legal range is 1..15

Ports:
- ck  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req0, req1  in  1  per-port access request
- we0, we1  in  1  per-port write enable (1 = write, 0 = read), qualified by req
- addr0, addr1  in  AW  per-port word address
- wdata0, wdata1  in  DW  per-port write data
- ack0, ack1  out  1  per-port: access performed in this cycle
- rdata0, rdata1  out  DW  per-port read data, valid while the port's ack is 1
- owner  out  2  current FSM state: 00 IDLE, 01 OWN0, 10 OWN1
- mem_ce  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  combinational read data from the memory

## Operation
- Registered state: FSM {IDLE, OWN0, OWN1}, burst counter cnt (4 bits), last-served bit `last`.
- Reset values: IDLE, cnt=0, last=1 (so port 0 wins the first tie).
- Combinational outputs:
  - ack0 = (state==OWN0) & req0; ack1 = (state==OWN1) & req1.
  - mem_ce = ack0 | ack1.
  - mem_we = (ack0 & we0) | (ack1 & we1).
  - mem_addr / mem_wdata come from the owning port; all zero in IDLE.
  - rdata0 = ack0 ? mem_rdata : 0; rdata1 = ack1 ? mem_rdata : 0.
- Transitions out of IDLE (no access occurs in IDLE):
  - req0 & req1: go to OWN(~last).
  - Only req0: go to OWN0.
  - Only req1: go to OWN1.
  - Neither: stay in IDLE.
  - cnt <= 0 in all cases.
- Transitions out of OWNx (y = the other port):
  - !req_x: go to OWNy if req_y, else IDLE. Set last<=x, cnt<=0. No access this cycle.
  - req_x & req_y & cnt==BURST_MAX-1: go to OWNy, last<=x, cnt<=0.
  - Otherwise: stay in OWNx. cnt <= cnt+1, saturating at BURST_MAX-1 (it saturates when there is no competitor).
- Handover goes directly OWNx -> OWNy with no IDLE bubble.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - After each ack, the requester may present the next access, or drop req.
- A write commits at the rising edge that ends the ack cycle.
- A read returns data in the ack cycle.

## Timing
- Latency:
  - req rising in IDLE at cycle N -> ack in cycle N+1.
  - Waiting while the other port owns the memory: ack at most BURST_MAX+1 cycles after req.
- Throughput: one access per cycle while a port owns the memory.
- Reset asserted mid-burst:
  - State, cnt and last clear immediately, without waiting for ck.
  - ack and mem_* go to 0 in the same cycle.
  - Any access in progress is not performed and not acknowledged.
- With BURST_MAX=1, concurrent requesters alternate on every access.

## Test plan
- Reset: hold rst=0 with random requests -> all ack, mem_ce, mem_we and owner read 0. After release, owner=00.
- Single read: preload mem[0x14]=0x000E; req0, we0=0, addr0=0x14 at cycle N -> ack0=1 and rdata0=0x000E in cycle N+1, mem_we=0.
- Write then read: port 1 writes 0x15<-0xBEEF (ack1 one cycle after req). Port 0 then reads 0x15 -> rdata0=0xBEEF.
- Contention, BURST_MAX=4, req0 and req1 both held high from reset release -> owner sequence IDLE, OWN0 x4, OWN1 x4, OWN0 x4. No gap cycles; mem_ce stays 1 after the first cycle.
- Early release: port 0 owns with cnt=1 and port 1 pending; drop req0 -> next cycle owner=OWN1 and ack1=1.
- Reset during an OWN1 burst with a write pending -> ack1 and mem_we fall asynchronously and memory is unchanged. After release with both requesting, port 0 is granted first.
